// File: rtl/systolic_conv_array_pkg.sv
// Shared types and width helpers for the systolic convolution array.
package systolic_conv_array_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_LOAD_PX = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Ceiling log2 with a floor of 1 so single-entry counters still get a bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int acc_width(input int dw, input int k);
    return 2 * dw + clog2(k * k);
  endfunction

endpackage

// File: rtl/systolic_conv_array_conv_row_mac.sv
// One kernel row: K products added to the incoming partial sum, registered.
// Latency 1 cycle; holds its output while en is low (pipeline stall).
module conv_row_mac #(
  parameter int DW = 8,
  parameter int K  = 3,
  parameter int AW = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [K*DW-1:0] px_row,
  input  logic [K*DW-1:0] w_row,
  input  logic [AW-1:0]   psum_in,
  output logic [AW-1:0]   psum_out
);

  logic [2*DW-1:0] prod [K];
  logic [AW-1:0]   sum;

  always_comb begin
    sum = psum_in;
    for (int s = 0; s < K; s++) begin
      prod[s] = {{DW{1'b0}}, px_row[s*DW +: DW]} * {{DW{1'b0}}, w_row[s*DW +: DW]};
      sum     = sum + AW'(prod[s]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psum_out <= '0;
    end else if (en) begin
      psum_out <= sum;
    end
  end

endmodule

// File: rtl/systolic_conv_array.sv
// Valid-convolution engine: buffers weights and one image, then streams results through a K-stage row pipeline.
// First result K cycles after compute starts, one per cycle; the whole pipeline freezes while res_valid & !res_ready.
module systolic_conv_array
  import systolic_conv_array_pkg::*;
#(
  parameter int DW  = 8,
  parameter int K   = 3,
  parameter int IMG = 4,
  parameter int SAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          reuse_w,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [DW-1:0] w_data,
  input  logic          px_valid,
  output logic          px_ready,
  input  logic [DW-1:0] px_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          busy,
  output logic          done
);

  localparam int OUT = IMG - K + 1;
  localparam int AW  = acc_width(DW, K);
  localparam int WCW = clog2(K * K);
  localparam int PAW = clog2(IMG * IMG);
  localparam int IW  = clog2(OUT);
  localparam int RCW = clog2(OUT * OUT);

  localparam logic [WCW-1:0] W_LAST  = WCW'(K * K - 1);
  localparam logic [PAW-1:0] PX_LAST = PAW'(IMG * IMG - 1);
  localparam logic [IW-1:0]  O_LAST  = IW'(OUT - 1);
  localparam logic [RCW-1:0] R_LAST  = RCW'(OUT * OUT - 1);

  state_t         state;
  logic [WCW-1:0] w_cnt;
  logic [PAW-1:0] px_cnt;
  logic [IW-1:0]  oi, oj;
  logic [RCW-1:0] res_cnt;
  logic           w_ok;
  logic           adv;

  logic [DW-1:0]  w_mem  [K*K];
  logic [DW-1:0]  px_mem [IMG*IMG];

  logic [K-1:0]    st_vld;
  logic [IW-1:0]   st_oi [K-1];
  logic [IW-1:0]   st_oj [K-1];
  logic [IW-1:0]   in_oi [K];
  logic [IW-1:0]   in_oj [K];
  logic [K*DW-1:0] row_px [K];
  logic [K*DW-1:0] row_w  [K];
  logic [AW-1:0]   ps_in  [K];
  logic [AW-1:0]   psum   [K];
  logic            sum_hi;

  assign w_ready   = (state == S_LOAD_W);
  assign px_ready  = (state == S_LOAD_PX);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign res_valid = st_vld[K-1];
  assign adv       = !res_valid || res_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      w_cnt  <= '0;
      px_cnt <= '0;
      oi     <= '0;
      oj     <= '0;
      w_ok   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (reuse_w && w_ok) begin
              state <= S_LOAD_PX;
            end else begin
              state <= S_LOAD_W;
              w_ok  <= 1'b0;
            end
          end
        end
        S_LOAD_W: begin
          if (w_valid) begin
            if (w_cnt == W_LAST) begin
              w_cnt <= '0;
              w_ok  <= 1'b1;
              state <= S_LOAD_PX;
            end else begin
              w_cnt <= w_cnt + 1'b1;
            end
          end
        end
        S_LOAD_PX: begin
          if (px_valid) begin
            if (px_cnt == PX_LAST) begin
              px_cnt <= '0;
              state  <= S_COMPUTE;
            end else begin
              px_cnt <= px_cnt + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (adv) begin
            if (oj == O_LAST) begin
              oj <= '0;
              if (oi == O_LAST) begin
                oi    <= '0;
                state <= S_DRAIN;
              end else begin
                oi <= oi + 1'b1;
              end
            end else begin
              oj <= oj + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (res_valid && res_ready && res_cnt == R_LAST) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_cnt <= '0;
    end else if (res_valid && res_ready) begin
      res_cnt <= (res_cnt == R_LAST) ? '0 : res_cnt + 1'b1;
    end
  end

  // Buffers carry no reset: their contents only matter once loaded.
  always_ff @(posedge clk) begin
    if (state == S_LOAD_W && w_valid) w_mem[w_cnt] <= w_data;
    if (state == S_LOAD_PX && px_valid) px_mem[px_cnt] <= px_data;
  end

  // Output coordinates travel with the partial sum so each stage fetches its own pixel row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_vld <= '0;
      for (int r = 0; r < K - 1; r++) begin
        st_oi[r] <= '0;
        st_oj[r] <= '0;
      end
    end else if (adv) begin
      st_vld <= {st_vld[K-2:0], (state == S_COMPUTE)};
      st_oi[0] <= oi;
      st_oj[0] <= oj;
      for (int r = 1; r < K - 1; r++) begin
        st_oi[r] <= st_oi[r-1];
        st_oj[r] <= st_oj[r-1];
      end
    end
  end

  always_comb begin
    in_oi[0] = oi;
    in_oj[0] = oj;
    for (int r = 1; r < K; r++) begin
      in_oi[r] = st_oi[r-1];
      in_oj[r] = st_oj[r-1];
    end
  end

  always_comb begin
    for (int r = 0; r < K; r++) begin
      row_px[r] = '0;
      row_w[r]  = '0;
      for (int s = 0; s < K; s++) begin
        row_px[r][s*DW +: DW] = px_mem[PAW'((int'(in_oi[r]) + r) * IMG + int'(in_oj[r]) + s)];
        row_w[r][s*DW +: DW]  = w_mem[WCW'(r * K + s)];
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    if (r == 0) begin : g_first
      assign ps_in[r] = '0;
    end else begin : g_chain
      assign ps_in[r] = psum[r-1];
    end

    conv_row_mac #(.DW(DW), .K(K), .AW(AW)) u_mac (
      .clk      (clk),
      .rst      (rst),
      .en       (adv),
      .px_row   (row_px[r]),
      .w_row    (row_w[r]),
      .psum_in  (ps_in[r]),
      .psum_out (psum[r])
    );
  end

  assign sum_hi   = |psum[K-1][AW-1:DW];
  assign res_data = (SAT != 0 && sum_hi) ? {DW{1'b1}} : psum[K-1][DW-1:0];

endmodule
